// File: rtl/epsilon_conditioner.sv
// epsilon_conditioner: syncs a raw entropy pin, samples it on sample_en,
// optionally von-Neumann debiases, and frames BLOCK_LEN bits for monobit.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   raw_in              asynchronous raw entropy bit
//   sample_en           take one sample of the synchronised bit
//   vn_en               debias enable, latched at block start
//   start               begin a block (IDLE only)
//   epsilon_dat/_vld    emitted bit and its one-cycle qualifier
//   block_last          qualifies the final bit of a block
//   busy, done          RUN/DONE indicator, one-cycle completion pulse
//   bit_count           bits emitted in current/last block
//   discard_count       saturating count of discarded equal pairs
module epsilon_conditioner #(
  parameter int BLOCK_LEN = 128,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_in,
  input  logic             sample_en,
  input  logic             vn_en,
  input  logic             start,
  output logic             epsilon_dat,
  output logic             epsilon_vld,
  output logic             block_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] discard_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] SAT      = '1;

  state_t state_q;
  state_t state_d;

  logic sync1;
  logic sync2;
  logic first_bit;
  logic have_first;
  logic vn_mode;

  logic start_acc;
  logic take;
  logic emit;
  logic emit_bit;
  logic discard;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      // block_last is registered, so DONE lands one cycle after the
      // final bit is presented.
      RUN:     if (block_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_acc = (state_q == IDLE) && start;
    // Once the final bit is out, further samples are dropped.
    take      = (state_q == RUN) && sample_en && !block_last;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    discard   = 1'b0;
    if (take) begin
      if (!vn_mode) begin
        emit     = 1'b1;
        emit_bit = sync2;
      end else if (have_first) begin
        if (sync2 != first_bit) begin
          emit     = 1'b1;
          emit_bit = first_bit;
        end else begin
          discard = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      first_bit     <= 1'b0;
      have_first    <= 1'b0;
      vn_mode       <= 1'b0;
      epsilon_dat   <= 1'b0;
      epsilon_vld   <= 1'b0;
      block_last    <= 1'b0;
      bit_count     <= '0;
      discard_count <= '0;
    end else begin
      state_q     <= state_d;
      sync1       <= raw_in;
      sync2       <= sync1;
      epsilon_vld <= emit;
      block_last  <= emit && (bit_count == LAST_IDX);
      if (emit) begin
        epsilon_dat <= emit_bit;
        bit_count   <= bit_count + 1'b1;
      end
      if (take && vn_mode) begin
        have_first <= !have_first;
        if (!have_first) first_bit <= sync2;
      end
      if (discard && (discard_count != SAT)) begin
        discard_count <= discard_count + 1'b1;
      end
      if (start_acc) begin
        bit_count     <= '0;
        discard_count <= '0;
        have_first    <= 1'b0;
        vn_mode       <= vn_en;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_epsilon_conditioner.sv
// tb_epsilon_conditioner: directed and randomized checks of
// epsilon_conditioner with BLOCK_LEN=4 (u4) and BLOCK_LEN=2 (u2).
module tb_epsilon_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic raw_in;
  logic sample_en;
  logic vn_en;
  logic start;

  logic       a_dat, a_vld, a_last, a_busy, a_done;
  logic [7:0] a_bc, a_dc;
  logic       b_dat, b_vld, b_last, b_busy, b_done;
  logic [7:0] b_bc, b_dc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  epsilon_conditioner #(.BLOCK_LEN(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .sample_en(sample_en), .vn_en(vn_en), .start(start),
    .epsilon_dat(a_dat), .epsilon_vld(a_vld),
    .block_last(a_last), .busy(a_busy), .done(a_done),
    .bit_count(a_bc), .discard_count(a_dc)
  );

  epsilon_conditioner #(.BLOCK_LEN(2), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .sample_en(sample_en), .vn_en(vn_en), .start(start),
    .epsilon_dat(b_dat), .epsilon_vld(b_vld),
    .block_last(b_last), .busy(b_busy), .done(b_done),
    .bit_count(b_bc), .discard_count(b_dc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic v);
    raw_in = v;
    repeat (3) tick();
  endtask

  task automatic do_rst();
    rst_n     = 1'b0;
    start     = 1'b0;
    sample_en = 1'b0;
    vn_en     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    logic m_vn;
    logic v;
    logic exp_v;
    logic exp_d;
    logic q[$];
    int   emitted;
    int   disc;
    int   n;
    int   rep;
    logic vn_bits[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic vn_ev[3]   = '{1'b1, 1'b0, 1'b1};
    logic vn_ed[3]   = '{1'b0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    raw_in    = 1'b0;
    sample_en = 1'b0;
    vn_en     = 1'b0;
    start     = 1'b0;

    // reset with random inputs
    repeat (2) begin
      raw_in    = 1'($urandom_range(0, 1));
      sample_en = 1'($urandom_range(0, 1));
      vn_en     = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_a", 32'({a_dat, a_vld, a_last, a_busy, a_done, a_bc, a_dc}),
        32'd0);
    chk("rst_b", 32'({b_dat, b_vld, b_last, b_busy, b_done, b_bc, b_dc}),
        32'd0);
    rst_n     = 1'b1;
    start     = 1'b0;
    sample_en = 1'b0;
    vn_en     = 1'b0;

    // raw block, sample_en with start ignored, start in RUN ignored
    set_raw(1'b1);
    start     = 1'b1;
    sample_en = 1'b1;
    tick();
    start = 1'b0;
    chk("raw_same_cyc_vld", 32'(a_vld), 32'd0);
    chk("raw_busy_on", 32'(a_busy), 32'd1);
    chk("raw_bc0", 32'(a_bc), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      sample_en = 1'b1;
      start     = (i == 2);
      tick();
      chk("raw_vld", 32'(a_vld), 32'd1);
      chk("raw_dat", 32'(a_dat), 32'd1);
      chk("raw_last", 32'(a_last), 32'(i == 4));
      chk("raw_bc", 32'(a_bc), 32'(i));
    end
    sample_en = 1'b0;
    start     = 1'b0;
    tick();
    chk("raw_done", 32'(a_done), 32'd1);
    chk("raw_busy_done", 32'(a_busy), 32'd1);
    chk("raw_vld_off", 32'(a_vld), 32'd0);
    chk("raw_bc_final", 32'(a_bc), 32'd4);
    tick();
    chk("raw_busy_off", 32'(a_busy), 32'd0);
    chk("raw_done_off", 32'(a_done), 32'd0);
    chk("raw_bc_hold", 32'(a_bc), 32'd4);
    chk("raw_dat_hold", 32'(a_dat), 32'd1);

    // abort mid-block
    do_rst();
    set_raw(1'b1);
    start = 1'b1;
    tick();
    start     = 1'b0;
    sample_en = 1'b1;
    repeat (2) tick();
    sample_en = 1'b0;
    chk("abort_bc2", 32'(a_bc), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_zero",
        32'({a_dat, a_vld, a_last, a_busy, a_done, a_bc, a_dc}), 32'd0);
    saw = 1'b0;
    repeat (6) begin
      tick();
      saw = saw | a_done;
    end
    chk("abort_no_done", 32'(saw), 32'd0);

    // VN pairs on u2, vn_en dropped mid-block
    do_rst();
    vn_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vn_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      set_raw(vn_bits[2*p]);
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      chk("vn_first_vld", 32'(b_vld), 32'd0);
      set_raw(vn_bits[2*p+1]);
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      chk("vn_vld", 32'(b_vld), 32'(vn_ev[p]));
      if (vn_ev[p]) begin
        chk("vn_dat", 32'(b_dat), 32'(vn_ed[p]));
        chk("vn_last", 32'(b_last), 32'(p == 2));
      end
    end
    tick();
    chk("vn_done", 32'(b_done), 32'd1);
    chk("vn_bc", 32'(b_bc), 32'd2);
    chk("vn_dc", 32'(b_dc), 32'd1);

    // discard saturation
    do_rst();
    set_raw(1'b0);
    vn_en = 1'b1;
    start = 1'b1;
    tick();
    start     = 1'b0;
    sample_en = 1'b1;
    saw       = 1'b0;
    repeat (600) begin
      tick();
      saw = saw | b_vld;
    end
    sample_en = 1'b0;
    chk("sat_dc", 32'(b_dc), 32'd255);
    chk("sat_no_vld", 32'(saw), 32'd0);
    chk("sat_busy", 32'(b_busy), 32'd1);
    chk("sat_bc", 32'(b_bc), 32'd0);

    // randomized blocks on u4 against a pair-queue model
    do_rst();
    for (int blk = 0; blk < 8; blk++) begin
      m_vn  = 1'($urandom_range(0, 1));
      vn_en = m_vn;
      start = 1'b1;
      tick();
      start = 1'b0;
      vn_en = 1'($urandom_range(0, 1));
      q.delete();
      emitted = 0;
      disc    = 0;
      n       = 0;
      while (emitted < 4 && n < 400) begin
        v = 1'($urandom_range(0, 1));
        set_raw(v);
        rep = $urandom_range(1, 2);
        for (int k = 0; k < rep && emitted < 4; k++) begin
          exp_v = 1'b0;
          exp_d = 1'b0;
          if (!m_vn) begin
            exp_v = 1'b1;
            exp_d = v;
          end else begin
            q.push_back(v);
            if (q.size() == 2) begin
              if (q[0] != q[1]) begin
                exp_v = 1'b1;
                exp_d = q[0];
              end else if (disc < 255) begin
                disc++;
              end
              q.delete();
            end
          end
          if (exp_v) emitted++;
          sample_en = 1'b1;
          tick();
          n++;
          chk("rnd_vld", 32'(a_vld), 32'(exp_v));
          if (exp_v) begin
            chk("rnd_dat", 32'(a_dat), 32'(exp_d));
            chk("rnd_last", 32'(a_last), 32'(emitted == 4));
          end
          chk("rnd_bc", 32'(a_bc), 32'(emitted));
          chk("rnd_dc", 32'(a_dc), 32'(disc));
        end
        sample_en = 1'b0;
      end
      tick();
      chk("rnd_done", 32'(a_done), 32'd1);
      tick();
      chk("rnd_idle", 32'(a_busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
